// File: rtl/eth_tx_frame_queue.sv
// Multi-slot Ethernet TX frame queue. The fill side writes words into the current
// slot and commits frames by byte length. The drain side streams committed frames
// in order as AXI-Stream beats with tkeep/tlast, prefetching through a 2-entry FIFO.
module eth_tx_frame_queue #(
  parameter int unsigned axis_data_width_p = 64,
  parameter int unsigned slots_p           = 4,
  parameter int unsigned slot_words_p      = 256,
  parameter int unsigned len_width_p       = $clog2(slot_words_p * (axis_data_width_p / 8)) + 1
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [axis_data_width_p-1:0]     wr_data_i,
  input  logic                             wr_v_i,
  output logic                             wr_ready_and_o,
  input  logic [len_width_p-1:0]           commit_len_i,
  input  logic                             commit_v_i,
  output logic                             commit_ready_and_o,
  input  logic                             abort_i,
  output logic [axis_data_width_p-1:0]     tx_axis_tdata_o,
  output logic [axis_data_width_p/8-1:0]   tx_axis_tkeep_o,
  output logic                             tx_axis_tvalid_o,
  input  logic                             tx_axis_tready_i,
  output logic                             tx_axis_tlast_o,
  output logic                             tx_axis_tuser_o,
  output logic [$clog2(slots_p+1)-1:0]     free_slots_o,
  output logic [15:0]                      sent_count_o,
  output logic [15:0]                      drop_count_o
);

  localparam int unsigned B     = axis_data_width_p / 8;
  localparam int unsigned BW    = $clog2(B);
  localparam int unsigned DW    = axis_data_width_p;
  localparam int unsigned LW    = len_width_p;
  localparam int unsigned SIW   = $clog2(slots_p);
  localparam int unsigned WAW   = $clog2(slot_words_p);
  localparam int unsigned WCW   = WAW + 1;
  localparam int unsigned FSW   = $clog2(slots_p + 1);
  localparam int unsigned AW    = SIW + WAW;
  localparam int unsigned DEPTH = slots_p * slot_words_p;

  typedef enum logic {ST_IDLE, ST_READ} state_e;

  // Fill / queue bookkeeping
  logic [SIW-1:0] fp_q, rp_q;
  logic [WCW-1:0] wc_q;
  logic [FSW-1:0] free_q, pend_q;
  logic [LW-1:0]  len_q [slots_p];
  logic [15:0]    sent_q, drop_q;

  // Drain FSM
  state_e         state_q, state_d;
  logic [SIW-1:0] rslot_q, rslot_d;
  logic [WAW-1:0] rb_q, rb_d, nb_q, nb_d;
  logic [B-1:0]   keepl_q, keepl_d;

  // Memory and read pipeline
  logic [DW-1:0]  mem [DEPTH];
  logic [DW-1:0]  rdata_q;
  logic           rv_q;
  logic [B-1:0]   rkeep_q;
  logic           rlast_q;

  // Output FIFO
  logic [DW-1:0]  fq_data_q [2];
  logic [B-1:0]   fq_keep_q [2];
  logic           fq_last_q [2];
  logic           fq_head_q;
  logic [1:0]     fq_cnt_q;

  logic           wr_fire, commit_fire, commit_ok;
  logic [LW-1:0]  cap_bytes, head_len;
  logic [WAW-1:0] head_nb;
  logic [B-1:0]   head_keepl;
  logic           credit_ok, rd_en, rd_last, start, slot_free;
  logic [AW-1:0]  rd_addr;
  logic [B-1:0]   rd_keep;
  logic           out_from_fq, out_v, pop, fq_pop, push, fq_wsel, out_last;

  // Byte enables of the final beat: low rem bytes, or all bytes when rem is zero.
  function automatic logic [B-1:0] last_keep(input logic [BW-1:0] rem);
    logic [B-1:0] k;
    for (int i = 0; i < int'(B); i++) k[i] = (rem == '0) || (BW'(i) < rem);
    return k;
  endfunction

  assign wr_ready_and_o     = (free_q != '0) && (wc_q < WCW'(slot_words_p)) && !commit_v_i && !abort_i;
  assign commit_ready_and_o = (free_q != '0) && !abort_i;
  assign wr_fire            = wr_v_i && wr_ready_and_o;
  assign commit_fire        = commit_v_i && commit_ready_and_o;
  assign cap_bytes          = LW'(wc_q) << BW;
  assign commit_ok          = commit_fire && (commit_len_i != '0) && (commit_len_i <= cap_bytes);

  assign head_len   = len_q[rp_q];
  assign head_nb    = WAW'((head_len - LW'(1)) >> BW);
  assign head_keepl = last_keep(head_len[BW-1:0]);
  assign credit_ok  = (3'(fq_cnt_q) + 3'(rv_q)) < 3'd2;

  // Drain FSM state register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      rslot_q <= '0;
      rb_q    <= '0;
      nb_q    <= '0;
      keepl_q <= '0;
    end else begin
      state_q <= state_d;
      rslot_q <= rslot_d;
      rb_q    <= rb_d;
      nb_q    <= nb_d;
      keepl_q <= keepl_d;
    end
  end

  // IDLE issues beat 0 of the next frame itself so frames chain without a bubble.
  always_comb begin
    state_d = state_q;
    rslot_d = rslot_q;
    rb_d    = rb_q;
    nb_d    = nb_q;
    keepl_d = keepl_q;
    rd_en   = 1'b0;
    rd_addr = '0;
    rd_keep = '1;
    rd_last = 1'b0;
    start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((pend_q != '0) && credit_ok) begin
          start   = 1'b1;
          rd_en   = 1'b1;
          rd_addr = {rp_q, WAW'(0)};
          rd_last = (head_nb == '0);
          rd_keep = rd_last ? head_keepl : '1;
          if (!rd_last) begin
            state_d = ST_READ;
            rslot_d = rp_q;
            rb_d    = WAW'(1);
            nb_d    = head_nb;
            keepl_d = head_keepl;
          end
        end
      end
      ST_READ: begin
        if (credit_ok) begin
          rd_en   = 1'b1;
          rd_addr = {rslot_q, rb_q};
          rd_last = (rb_q == nb_q);
          rd_keep = rd_last ? keepl_q : '1;
          if (rd_last) state_d = ST_IDLE;
          else         rb_d    = rb_q + WAW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign slot_free = rd_en && rd_last;

  // Fill pointer, word count, per-slot committed length and drop counter.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fp_q   <= '0;
      wc_q   <= '0;
      drop_q <= '0;
      for (int i = 0; i < int'(slots_p); i++) len_q[i] <= '0;
    end else begin
      if (abort_i || commit_fire) wc_q <= '0;
      else if (wr_fire)           wc_q <= wc_q + WCW'(1);
      if (commit_ok) begin
        len_q[fp_q] <= commit_len_i;
        fp_q        <= fp_q + SIW'(1);
      end else if (commit_fire) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  // Free-slot count, frames waiting to start, and drain slot pointer.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      free_q <= FSW'(slots_p);
      pend_q <= '0;
      rp_q   <= '0;
    end else begin
      if (commit_ok && !slot_free)      free_q <= free_q - FSW'(1);
      else if (!commit_ok && slot_free) free_q <= free_q + FSW'(1);
      if (commit_ok && !start)          pend_q <= pend_q + FSW'(1);
      else if (!commit_ok && start)     pend_q <= pend_q - FSW'(1);
      if (start) rp_q <= rp_q + SIW'(1);
    end
  end

  // Slot memory: fill-side write port, drain-side synchronous read port.
  always_ff @(posedge clk_i) begin
    if (wr_fire) mem[{fp_q, wc_q[WAW-1:0]}] <= wr_data_i;
    if (rd_en)   rdata_q <= mem[rd_addr];
  end

  // Sideband travelling alongside the in-flight read.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rv_q    <= 1'b0;
      rkeep_q <= '0;
      rlast_q <= 1'b0;
    end else begin
      rv_q <= rd_en;
      if (rd_en) begin
        rkeep_q <= rd_keep;
        rlast_q <= rd_last;
      end
    end
  end

  // Read data bypasses the FIFO when it is empty and the MAC takes the beat at once.
  assign out_from_fq = (fq_cnt_q != 2'd0);
  assign out_v       = out_from_fq || rv_q;
  assign pop         = out_v && tx_axis_tready_i;
  assign fq_pop      = pop && out_from_fq;
  assign push        = rv_q && !(pop && !out_from_fq);
  assign fq_wsel     = fq_head_q ^ fq_cnt_q[0];
  assign out_last    = out_from_fq ? fq_last_q[fq_head_q] : rlast_q;

  // Output FIFO storage and pointers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fq_head_q <= 1'b0;
      fq_cnt_q  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fq_data_q[i] <= '0;
        fq_keep_q[i] <= '0;
        fq_last_q[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        fq_data_q[fq_wsel] <= rdata_q;
        fq_keep_q[fq_wsel] <= rkeep_q;
        fq_last_q[fq_wsel] <= rlast_q;
      end
      if (fq_pop) fq_head_q <= ~fq_head_q;
      fq_cnt_q <= fq_cnt_q + 2'(push) - 2'(fq_pop);
    end
  end

  // Completed-frame counter.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)           sent_q <= '0;
    else if (pop && out_last) sent_q <= sent_q + 16'd1;
  end

  // Stream outputs, forced to zero while no beat is presented.
  always_comb begin
    tx_axis_tvalid_o = out_v;
    tx_axis_tdata_o  = '0;
    tx_axis_tkeep_o  = '0;
    tx_axis_tlast_o  = 1'b0;
    tx_axis_tuser_o  = 1'b0;
    if (out_v) begin
      tx_axis_tdata_o = out_from_fq ? fq_data_q[fq_head_q] : rdata_q;
      tx_axis_tkeep_o = out_from_fq ? fq_keep_q[fq_head_q] : rkeep_q;
      tx_axis_tlast_o = out_last;
    end
  end

  assign free_slots_o = free_q;
  assign sent_count_o = sent_q;
  assign drop_count_o = drop_q;

endmodule

// File: doc/eth_tx_frame_queue.md
# eth_tx_frame_queue

Multi-slot transmit frame queue for the Ethernet controller, the parametrised successor to the single-register MMIO transmit path. The MMIO decode logic pushes AXIS-width words into a fill slot and commits each frame with a byte length. Committed frames are then streamed in order to the MAC's AXI-Stream TX input, with per-beat tkeep/tlast generation and full-throughput prefetch. The number of slots, the slot depth and the stream width are parameters; the block also adds abort, length checking and status counters.

## Interface
- axis_data_width_p, 64, stream/word width in bits; 32 or 64; B = axis_data_width_p/8 bytes per beat
- slots_p, 4, frame slots; power of 2, ≥2
- slot_words_p, 256, words per slot; power of 2
- len_width_p, $clog2(slot_words_p*B)+1, byte-length field width
- clk_i  in  1  clock
- reset_n_i  in  1  reset, asynchronous, active-low
- wr_data_i  in  axis_data_width_p  frame word, byte 0 in bits [7:0]
- wr_v_i  in  1  word valid
- wr_ready_and_o  out  1  word accepted when wr_v_i & wr_ready_and_o
- commit_len_i  in  len_width_p  frame byte length L
- commit_v_i  in  1  commit request
- commit_ready_and_o  out  1  commit accepted when commit_v_i & commit_ready_and_o
- abort_i  in  1  discard fill-slot contents
- tx_axis_tdata_o  out  axis_data_width_p  stream data
- tx_axis_tkeep_o  out  B  byte enables
- tx_axis_tvalid_o  out  1  beat valid
- tx_axis_tready_i  in  1  MAC ready
- tx_axis_tlast_o  out  1  last beat of frame
- tx_axis_tuser_o  out  1  always 0
- free_slots_o  out  $clog2(slots_p+1)  slots not holding committed, unread frames
- sent_count_o  out  16  frames completed (tlast handshakes), wraps
- drop_count_o  out  16  commits rejected for bad length, wraps

## Operation
- Storage: slots_p*slot_words_p-word 1r1w synchronous-read memory. Write and read in the same cycle are allowed; they always address different slots.
- Fill side: fill slot index fp and word counter wc (0..slot_words_p).
  - wr_ready_and_o = free_slots_o>0 & wc<slot_words_p & !commit_v_i & !abort_i.
  - Each accepted word is written at {fp,wc}; wc then increments.
- Commit: commit_ready_and_o = free_slots_o>0 & !abort_i.
  - A commit is valid iff 1 ≤ L ≤ wc*B.
  - Valid commit: record L for slot fp, enqueue fp, advance fp (mod slots_p), decrement free_slots_o.
  - Invalid commit: increment drop_count_o; the slot is not enqueued.
  - In both cases wc ← 0.
- Abort: wc ← 0. No counter changes. Abort takes priority over wr_v_i and commit_v_i in the same cycle.
- Drain FSM:
  - IDLE: if a committed frame exists, latch its L and slot, set beat counter rb←0, last beat index NB=ceil(L/B)-1, go to READ.
  - READ: issue a memory read of {slot,rb} whenever credits allow; increment rb.
    - The read of beat NB frees the slot (free_slots_o increments next cycle) and returns the FSM to IDLE. IDLE may start the next frame in that same following cycle.
- Output: 2-entry FIFO of {data,keep,last}.
  - A read is issued only if FIFO occupancy plus in-flight reads < 2.
  - This sustains 1 beat/cycle while tready is held high, across frame boundaries.
- tkeep: all ones, except on beat NB, where it is the low (L mod B) bits set, or all ones if L mod B = 0.
- tlast: set on beat NB only.
- sent_count_o increments on each tvalid & tready & tlast.
- free_slots_o = slots_p minus frames committed but not fully read. Simultaneous commit and slot free leaves it unchanged.

## Timing
- Reset (asynchronous, reset_n_i=0):
  - fp=0, wc=0, FSM IDLE, FIFO empty, counters 0, free_slots_o=slots_p.
  - tvalid_o=0, tlast_o=0, tkeep_o=0, tdata_o=0, tuser_o=0.
  - wr_ready_and_o=1 and commit_ready_and_o=1 (subject to their inputs).
- Reset mid-frame discards all queued and in-flight frames. No partial beats appear after reset release.
- Commit handshake in cycle N with the queue empty: first tvalid_o in cycle N+2.
- Holding tready_i=1: beats and frames stream back-to-back with no bubbles.
- tready_i=0: tdata/tkeep/tlast are held stable while tvalid_o=1.
- wr_ready_and_o may depend combinationally on commit_v_i and abort_i. No other combinational input-to-output paths exist.

## Test plan
- Frame L=60 (B=8): write words 0..7, commit 60, tready=1 → 8 beats with data 0..7, tkeep 0xFF×7 then 0x0F, tlast on beat 7, first tvalid 2 cycles after commit, sent_count_o=1.
- Fill all 4 slots with tready=0 → free_slots_o=0, wr_ready_and_o=0 and commit_ready_and_o=0; raise tready → 4 frames stream back-to-back with no idle cycles; free_slots_o returns to 4.
- Write 2 words, commit L=17 (needs 3 words) → drop_count_o=1, nothing streamed, free_slots_o=4; commit L=0 → drop_count_o=2.
- Write 3 words, pulse abort_i together with commit_v_i → commit not accepted; then write 1 word and commit L=8 → single beat carrying that word, tkeep 0xFF, tlast=1.
- Random tready throttling over 100 frames of random L 1..2048 → byte-exact stream versus scoreboard, stable outputs while stalled, sent_count_o=100.
- Assert reset_n_i mid-stream on beat 3 → outputs 0 immediately; after release, free_slots_o=4 and no residual beats appear.
